// File: rtl/systolic_pe_os_if.sv
// Link bundle for one output-stationary PE: operand inputs/forwards, drain chain and status.
// The array side drives through master; the PE attaches through slave.
interface systolic_pe_os_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic [DATA_W-1:0] a_in;
    logic              a_valid_in;
    logic [DATA_W-1:0] b_in;
    logic              b_valid_in;
    logic              acc_clr;
    logic              drain_start;
    logic [ACC_W-1:0]  c_in;
    logic              c_valid_in;
    logic [DATA_W-1:0] a_out;
    logic              a_valid_out;
    logic [DATA_W-1:0] b_out;
    logic              b_valid_out;
    logic [ACC_W-1:0]  c_out;
    logic              c_valid_out;
    logic              busy;
    logic              ovf;

    modport master (
        output a_in, a_valid_in, b_in, b_valid_in, acc_clr, drain_start, c_in, c_valid_in,
        input  a_out, a_valid_out, b_out, b_valid_out, c_out, c_valid_out, busy, ovf
    );

    modport slave (
        input  a_in, a_valid_in, b_in, b_valid_in, acc_clr, drain_start, c_in, c_valid_in,
        output a_out, a_valid_out, b_out, b_valid_out, c_out, c_valid_out, busy, ovf
    );
endinterface

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: local MAC accumulator with optional saturation,
// east/south operand forwarding, and a drain FSM that shifts results down the C chain.
module systolic_pe_os #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1,
    parameter int CHAIN_POS = 0
) (
    input  logic             clk,
    input  logic             rst,
    systolic_pe_os_if.slave  pe
);
    localparam int PW    = 2 * DATA_W;
    localparam int EW    = ACC_W + 1;
    localparam int CNT_W = (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic               cv_q, cv_d;
    logic [DATA_W-1:0]  a_q, b_q;
    logic               av_q, bv_q;

    logic [PW-1:0]      opa, opb, prod;
    logic [EW-1:0]      prod_ext, base_ext, sum;
    logic [ACC_W-1:0]   base, sat_val, mac_res, nxt_acc;
    logic               mac, ovf_det, nxt_ovf;

    // Operands are widened to PW first so the low PW bits of an unsigned
    // multiply are the correct two's-complement product in signed mode.
    always_comb begin
        if (SIGNED != 0) begin
            opa = {{DATA_W{pe.a_in[DATA_W-1]}}, pe.a_in};
            opb = {{DATA_W{pe.b_in[DATA_W-1]}}, pe.b_in};
        end else begin
            opa = {{DATA_W{1'b0}}, pe.a_in};
            opb = {{DATA_W{1'b0}}, pe.b_in};
        end
        prod     = opa * opb;
        prod_ext = {{(EW-PW){(SIGNED != 0) && prod[PW-1]}}, prod};
        base     = pe.acc_clr ? '0 : acc_q;
        base_ext = {(SIGNED != 0) && base[ACC_W-1], base};
        sum      = base_ext + prod_ext;
        if (SIGNED != 0) begin
            ovf_det = sum[ACC_W] ^ sum[ACC_W-1];
            sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf_det = sum[ACC_W];
            sat_val = '1;
        end
        mac_res = (ovf_det && (SATURATE != 0)) ? sat_val : sum[ACC_W-1:0];
        mac     = pe.a_valid_in && pe.b_valid_in;
        nxt_acc = mac ? mac_res : base;
        nxt_ovf = (pe.acc_clr ? 1'b0 : ovf_q) | (mac & ovf_det);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cv_d    = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (pe.drain_start) begin
                    c_d     = nxt_acc;
                    cv_d    = 1'b1;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    acc_d = nxt_acc;
                    ovf_d = nxt_ovf;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(CHAIN_POS)) begin
                    state_d = ACCUM;
                end else begin
                    c_d   = pe.c_in;
                    cv_d  = pe.c_valid_in;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            c_q     <= '0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cv_q    <= cv_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            av_q <= 1'b0;
            b_q  <= '0;
            bv_q <= 1'b0;
        end else begin
            a_q  <= pe.a_in;
            av_q <= pe.a_valid_in;
            b_q  <= pe.b_in;
            bv_q <= pe.b_valid_in;
        end
    end

    assign pe.a_out       = a_q;
    assign pe.a_valid_out = av_q;
    assign pe.b_out       = b_q;
    assign pe.b_valid_out = bv_q;
    assign pe.c_out       = c_q;
    assign pe.c_valid_out = cv_q;
    assign pe.busy        = (state_q == DRAIN);
    assign pe.ovf         = ovf_q;
endmodule

// File: tb/tb_systolic_pe_os.sv
// Directed bench for systolic_pe_os: single PEs in four arithmetic configurations
// sharing one stimulus bus, plus a three-PE drain column.
module tb_systolic_pe_os;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] a, b;
    logic       av, bv, clr, ds;
    logic [7:0] ca0, ca1, ca2;
    logic       cvld, cclr, cds;

    systolic_pe_os_if #(.DATA_W(8), .ACC_W(32)) if_s32 ();
    systolic_pe_os_if #(.DATA_W(8), .ACC_W(16)) if_s16s ();
    systolic_pe_os_if #(.DATA_W(8), .ACC_W(16)) if_s16w ();
    systolic_pe_os_if #(.DATA_W(8), .ACC_W(16)) if_u16 ();
    systolic_pe_os_if #(.DATA_W(8), .ACC_W(32)) if_c0 ();
    systolic_pe_os_if #(.DATA_W(8), .ACC_W(32)) if_c1 ();
    systolic_pe_os_if #(.DATA_W(8), .ACC_W(32)) if_c2 ();

    assign if_s32.a_in = a;   assign if_s32.a_valid_in = av;   assign if_s32.b_in = b;   assign if_s32.b_valid_in = bv;
    assign if_s32.acc_clr = clr;   assign if_s32.drain_start = ds;   assign if_s32.c_in = '0;   assign if_s32.c_valid_in = 1'b0;
    assign if_s16s.a_in = a;  assign if_s16s.a_valid_in = av;  assign if_s16s.b_in = b;  assign if_s16s.b_valid_in = bv;
    assign if_s16s.acc_clr = clr;  assign if_s16s.drain_start = ds;  assign if_s16s.c_in = '0;  assign if_s16s.c_valid_in = 1'b0;
    assign if_s16w.a_in = a;  assign if_s16w.a_valid_in = av;  assign if_s16w.b_in = b;  assign if_s16w.b_valid_in = bv;
    assign if_s16w.acc_clr = clr;  assign if_s16w.drain_start = ds;  assign if_s16w.c_in = '0;  assign if_s16w.c_valid_in = 1'b0;
    assign if_u16.a_in = a;   assign if_u16.a_valid_in = av;   assign if_u16.b_in = b;   assign if_u16.b_valid_in = bv;
    assign if_u16.acc_clr = clr;   assign if_u16.drain_start = ds;   assign if_u16.c_in = '0;   assign if_u16.c_valid_in = 1'b0;

    assign if_c0.a_in = ca0;  assign if_c0.a_valid_in = cvld;  assign if_c0.b_in = 8'd1;  assign if_c0.b_valid_in = cvld;
    assign if_c0.acc_clr = cclr;  assign if_c0.drain_start = cds;  assign if_c0.c_in = '0;  assign if_c0.c_valid_in = 1'b0;
    assign if_c1.a_in = ca1;  assign if_c1.a_valid_in = cvld;  assign if_c1.b_in = 8'd1;  assign if_c1.b_valid_in = cvld;
    assign if_c1.acc_clr = cclr;  assign if_c1.drain_start = cds;
    assign if_c1.c_in = if_c0.c_out;  assign if_c1.c_valid_in = if_c0.c_valid_out;
    assign if_c2.a_in = ca2;  assign if_c2.a_valid_in = cvld;  assign if_c2.b_in = 8'd1;  assign if_c2.b_valid_in = cvld;
    assign if_c2.acc_clr = cclr;  assign if_c2.drain_start = cds;
    assign if_c2.c_in = if_c1.c_out;  assign if_c2.c_valid_in = if_c1.c_valid_out;

    systolic_pe_os #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SATURATE(1), .CHAIN_POS(0))
        u_s32  (.clk(clk), .rst(rst), .pe(if_s32));
    systolic_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .CHAIN_POS(0))
        u_s16s (.clk(clk), .rst(rst), .pe(if_s16s));
    systolic_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0), .CHAIN_POS(0))
        u_s16w (.clk(clk), .rst(rst), .pe(if_s16w));
    systolic_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1), .CHAIN_POS(0))
        u_u16  (.clk(clk), .rst(rst), .pe(if_u16));
    systolic_pe_os #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SATURATE(1), .CHAIN_POS(0))
        u_c0   (.clk(clk), .rst(rst), .pe(if_c0));
    systolic_pe_os #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SATURATE(1), .CHAIN_POS(1))
        u_c1   (.clk(clk), .rst(rst), .pe(if_c1));
    systolic_pe_os #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SATURATE(1), .CHAIN_POS(2))
        u_c2   (.clk(clk), .rst(rst), .pe(if_c2));

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a = '0; b = '0; av = 1'b0; bv = 1'b0; clr = 1'b0; ds = 1'b0;
        ca0 = '0; ca1 = '0; ca2 = '0; cvld = 1'b0; cclr = 1'b0; cds = 1'b0;
        #12;
        check("rst_c_out", if_s32.c_out, 0);
        check("rst_c_valid", if_s32.c_valid_out, 0);
        check("rst_busy", if_s32.busy, 0);
        check("rst_ovf", if_s32.ovf, 0);
        check("rst_a_valid", if_s32.a_valid_out, 0);
        rst = 1'b0;

        // Signed MAC, 32-bit accumulator
        clr = 1'b1; av = 1'b1; bv = 1'b1; a = 8'hFD; b = 8'd5; tick();
        clr = 1'b0; a = 8'd7; b = 8'd4; tick();
        a = 8'h80; b = 8'h80; tick();
        av = 1'b0; bv = 1'b0;
        check("s32_acc", $signed(u_s32.acc_q), 16397);
        check("s32_ovf", if_s32.ovf, 0);
        ds = 1'b1; tick(); ds = 1'b0;
        check("s32_drain_c", $signed(if_s32.c_out), 16397);
        check("s32_drain_cv", if_s32.c_valid_out, 1);
        check("s32_drain_busy", if_s32.busy, 1);
        check("s32_post_acc", u_s32.acc_q, 0);
        tick();
        check("s32_end_cv", if_s32.c_valid_out, 0);
        check("s32_end_busy", if_s32.busy, 0);
        check("s32_hold_c", $signed(if_s32.c_out), 16397);

        // Signed 16-bit saturation vs wrap
        clr = 1'b1; av = 1'b1; bv = 1'b1; a = 8'd127; b = 8'd127; tick();
        clr = 1'b0;
        check("s16s_acc1", $signed(u_s16s.acc_q), 16129);
        tick();
        check("s16s_acc2", $signed(u_s16s.acc_q), 32258);
        check("s16s_ovf2", if_s16s.ovf, 0);
        tick();
        check("s16s_acc3", $signed(u_s16s.acc_q), 32767);
        check("s16s_ovf3", if_s16s.ovf, 1);
        check("s16w_acc3", $signed(u_s16w.acc_q), -17149);
        check("s16w_ovf3", if_s16w.ovf, 1);

        // Unsigned 16-bit saturation, then clear with simultaneous MAC
        clr = 1'b1; a = 8'd255; b = 8'd255; tick();
        clr = 1'b0;
        check("u16_acc1", u_u16.acc_q, 65025);
        tick();
        check("u16_acc2", u_u16.acc_q, 65535);
        check("u16_ovf2", if_u16.ovf, 1);
        clr = 1'b1; a = 8'd2; b = 8'd3; tick();
        clr = 1'b0;
        check("u16_clr_acc", u_u16.acc_q, 6);
        check("u16_clr_ovf", if_u16.ovf, 0);

        // Valid gating: only A valid, forwarding keeps going
        bv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'(11 * (i + 1)); tick();
            a = 8'h5A;
            check("fwd_a_out", if_s32.a_out, 11 * (i + 1));
            check("fwd_a_valid", if_s32.a_valid_out, 1);
        end
        check("fwd_b_valid", if_s32.b_valid_out, 0);
        av = 1'b0; tick();
        check("fwd_a_valid_drop", if_s32.a_valid_out, 0);
        check("gate_s32_acc", u_s32.acc_q, 6);
        check("gate_u16_acc", u_u16.acc_q, 6);

        // Drain coincident with a MAC
        clr = 1'b1; av = 1'b1; bv = 1'b1; a = 8'd10; b = 8'd10; tick();
        clr = 1'b0; a = 8'd2; b = 8'd3; ds = 1'b1; tick();
        ds = 1'b0; av = 1'b0; bv = 1'b0;
        check("dmac_c", if_s32.c_out, 106);
        check("dmac_cv", if_s32.c_valid_out, 1);
        check("dmac_acc", u_s32.acc_q, 0);
        tick();

        // Three-PE column drain
        cclr = 1'b1; cvld = 1'b1; ca0 = 8'd10; ca1 = 8'd20; ca2 = 8'd30; tick();
        cclr = 1'b0; cvld = 1'b0; cds = 1'b1; tick();
        cds = 1'b0; cvld = 1'b1; ca0 = 8'd5; ca1 = 8'd5; ca2 = 8'd5;
        check("col_t1_c2", if_c2.c_out, 30);
        check("col_t1_cv2", if_c2.c_valid_out, 1);
        check("col_t1_c1", if_c1.c_out, 20);
        check("col_t1_busy0", if_c0.busy, 1);
        check("col_t1_busy2", if_c2.busy, 1);
        tick();
        cvld = 1'b0;
        check("col_t2_c2", if_c2.c_out, 20);
        check("col_t2_cv2", if_c2.c_valid_out, 1);
        check("col_t2_busy0", if_c0.busy, 0);
        tick();
        check("col_t3_c2", if_c2.c_out, 10);
        check("col_t3_cv2", if_c2.c_valid_out, 1);
        tick();
        check("col_t4_cv2", if_c2.c_valid_out, 0);
        check("col_t4_busy1", if_c1.busy, 0);
        check("col_t4_busy2", if_c2.busy, 0);
        cds = 1'b1; tick(); cds = 1'b0;
        check("col_redrain_c2", if_c2.c_out, 0);
        tick(); tick(); tick();

        // Reset in the middle of a drain
        cclr = 1'b1; cvld = 1'b1; ca0 = 8'd10; ca1 = 8'd20; ca2 = 8'd30; tick();
        cclr = 1'b0; cvld = 1'b0; cds = 1'b1; tick();
        cds = 1'b0; tick();
        #3 rst = 1'b1;
        #1;
        check("rstd_c2", if_c2.c_out, 0);
        check("rstd_cv2", if_c2.c_valid_out, 0);
        check("rstd_busy2", if_c2.busy, 0);
        check("rstd_a_out", if_s32.a_out, 0);
        rst = 1'b0;
        tick();
        check("rstd_after_cv2", if_c2.c_valid_out, 0);
        check("rstd_after_busy2", if_c2.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
